core_run_monitor: RTL and testbench
===================================

CORE_RUN_MONITOR -- requirements
Module: core_run_monitor

Interface
REQ-001 Parameter STUCK_LIMIT, default 2000000, number of extra cycles mem_pc may repeat before a stuck halt.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000000, number of run cycles before a timeout halt.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 ecall_pulse  input  1  core ECALL retire pulse.
REQ-006 ebreak_pulse  input  1  core EBREAK retire pulse.
REQ-007 pc  input  32  core IF-stage PC.
REQ-008 mem_pc  input  32  core MEM-stage PC.
REQ-009 clear  input  1  return from HALT to RUN and zero all counters.
REQ-010 halted  output  1  monitor is in HALT.
REQ-011 halt_pulse  output  1  single-cycle strobe on entry to HALT.
REQ-012 halt_cause  output  3  0 none, 1 ecall, 2 ebreak, 3 stuck, 4 timeout.
REQ-013 halt_pc  output  32  PC captured at halt.
REQ-014 cycle_count  output  64  run cycles elapsed.
REQ-015 stuck_count  output  32  current repeat count of mem_pc.

Function
REQ-016 FSM SHALL have exactly two states, RUN and HALT; no other encodings reachable.
REQ-017 In RUN, each edge without a halt event SHALL increment cycle_count by 1, wrapping modulo 2^64.
REQ-018 Stuck tracker: at each RUN edge, if mem_pc equals stuck_pc register, stuck_count increments (saturating at 2^32-1); else stuck_pc loads mem_pc and stuck_count loads 0.
REQ-019 Halt events, evaluated at each RUN edge: ecall_pulse; ebreak_pulse; stuck_count register == STUCK_LIMIT; cycle_count register == TIMEOUT_CYCLES.
REQ-020 Simultaneous events SHALL resolve by priority ecall > ebreak > stuck > timeout; only the winner is recorded in halt_cause.
REQ-021 On a halt event: the state becomes HALT after that edge, halt_pulse is 1 for exactly the following cycle, and cycle_count does not increment on that edge.
REQ-022 halt_pc SHALL capture pc for ecall/ebreak, stuck_pc register for stuck, and mem_pc for timeout.
REQ-023 In HALT, cycle_count, stuck_count, stuck_pc, halt_cause and halt_pc SHALL hold; ecall/ebreak pulses SHALL be ignored.
REQ-024 clear in HALT SHALL go to RUN on the next edge with cycle_count=0, stuck_count=0, stuck_pc=32'hFFFFFFFF, halt_cause=0, halt_pc=0; clear in RUN SHALL be ignored.
REQ-025 halt_pulse SHALL never assert on two consecutive cycles.
REQ-026 Latency from a sampled event to halted=1 SHALL be exactly one edge; all outputs are registered.

Reset
REQ-027 rst SHALL override clear and all events, including mid-run and in HALT.
REQ-028 After rst: state RUN, halted=0, halt_pulse=0, halt_cause=0, halt_pc=0, cycle_count=0, stuck_count=0, stuck_pc=32'hFFFFFFFF.
REQ-029 The first edge after rst deasserts SHALL be counted as RUN cycle 1.

Verification (bench: STUCK_LIMIT=4, TIMEOUT_CYCLES=20)
REQ-030 rst 1 cycle, mem_pc incrementing by 4 each cycle, ecall_pulse at the 10th edge with pc=0x00000120 -> halted=1 and halt_pulse=1 after that edge, halt_cause=1, halt_pc=0x00000120, cycle_count=9.
REQ-031 mem_pc held at 0x00000040 from the first edge -> stuck_count reaches 4 after edge 5, halted rises after edge 6, halt_cause=3, halt_pc=0x00000040.
REQ-032 mem_pc always changing, no pulses -> halted rises after edge 21, halt_cause=4, cycle_count frozen at 20.
REQ-033 ecall_pulse and ebreak_pulse on the same edge while stuck_count==4 -> halt_cause=1; a later ebreak_pulse in HALT changes nothing and does not re-pulse halt_pulse.
REQ-034 In HALT assert clear for 1 cycle -> RUN with all counters zero and halt_cause=0; assert rst on the 3rd edge of a stuck run -> all outputs return to reset values, with no halt afterward until the conditions are met again.

Source files
------------

// File: rtl/core_run_monitor.sv
// Run/halt supervisor for a pipelined core: tracks run cycles and a repeating MEM-stage PC,
// and halts on ECALL, EBREAK, a stuck PC or a run-cycle timeout, recording cause and PC.
module core_run_monitor #(
   parameter logic [31:0] STUCK_LIMIT    = 32'd2000000,
   parameter logic [63:0] TIMEOUT_CYCLES = 64'd50000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ecall_pulse,
   input  logic        ebreak_pulse,
   input  logic [31:0] pc,
   input  logic [31:0] mem_pc,
   input  logic        clear,
   output logic        halted,
   output logic        halt_pulse,
   output logic [2:0]  halt_cause,
   output logic [31:0] halt_pc,
   output logic [63:0] cycle_count,
   output logic [31:0] stuck_count
);

   // state | meaning
   // RUN   | core executing; counters advance, halt events evaluated every edge
   // HALT  | core stopped; all captured state frozen until clear or rst
   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

   localparam logic [2:0] CAUSE_NONE    = 3'd0;
   localparam logic [2:0] CAUSE_ECALL   = 3'd1;
   localparam logic [2:0] CAUSE_EBREAK  = 3'd2;
   localparam logic [2:0] CAUSE_STUCK   = 3'd3;
   localparam logic [2:0] CAUSE_TIMEOUT = 3'd4;

   state_t      state;
   logic [31:0] stuck_pc;
   logic [2:0]  event_cause;
   logic [31:0] event_pc;

   // Priority: ecall > ebreak > stuck > timeout; the winner also selects the captured PC.
   always_comb begin
      event_cause = CAUSE_NONE;
      event_pc    = 32'h0;
      if (ecall_pulse) begin
         event_cause = CAUSE_ECALL;
         event_pc    = pc;
      end else if (ebreak_pulse) begin
         event_cause = CAUSE_EBREAK;
         event_pc    = pc;
      end else if (stuck_count == STUCK_LIMIT) begin
         event_cause = CAUSE_STUCK;
         event_pc    = stuck_pc;
      end else if (cycle_count == TIMEOUT_CYCLES) begin
         event_cause = CAUSE_TIMEOUT;
         event_pc    = mem_pc;
      end
   end

   assign halted = (state == HALT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         halt_pulse  <= 1'b0;
         halt_cause  <= CAUSE_NONE;
         halt_pc     <= 32'h0;
         cycle_count <= 64'h0;
         stuck_count <= 32'h0;
         stuck_pc    <= 32'hFFFF_FFFF;
      end else begin
         case (state)
            RUN: begin
               halt_pulse <= 1'b0;
               // The stuck tracker keeps running on the halting edge as well.
               if (mem_pc == stuck_pc) begin
                  if (stuck_count != 32'hFFFF_FFFF)
                     stuck_count <= stuck_count + 32'd1;
               end else begin
                  stuck_pc    <= mem_pc;
                  stuck_count <= 32'h0;
               end
               if (event_cause != CAUSE_NONE) begin
                  state      <= HALT;
                  halt_pulse <= 1'b1;
                  halt_cause <= event_cause;
                  halt_pc    <= event_pc;
               end else begin
                  cycle_count <= cycle_count + 64'd1;
               end
            end
            HALT: begin
               halt_pulse <= 1'b0;
               if (clear) begin
                  state       <= RUN;
                  halt_cause  <= CAUSE_NONE;
                  halt_pc     <= 32'h0;
                  cycle_count <= 64'h0;
                  stuck_count <= 32'h0;
                  stuck_pc    <= 32'hFFFF_FFFF;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_core_run_monitor.sv
// Self-checking bench for core_run_monitor: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_core_run_monitor;
   localparam logic [31:0] SL = 32'd4;
   localparam logic [63:0] TO = 64'd20;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ecall_pulse = 1'b0;
   logic        ebreak_pulse = 1'b0;
   logic        clear = 1'b0;
   logic [31:0] pc = 32'h0;
   logic [31:0] mem_pc = 32'h0;
   logic        halted;
   logic        halt_pulse;
   logic [2:0]  halt_cause;
   logic [31:0] halt_pc;
   logic [63:0] cycle_count;
   logic [31:0] stuck_count;

   core_run_monitor #(.STUCK_LIMIT(SL), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .ecall_pulse(ecall_pulse), .ebreak_pulse(ebreak_pulse),
      .pc(pc), .mem_pc(mem_pc), .clear(clear), .halted(halted), .halt_pulse(halt_pulse),
      .halt_cause(halt_cause), .halt_pc(halt_pc), .cycle_count(cycle_count),
      .stuck_count(stuck_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   bit          m_halted;
   bit          m_pulse;
   logic [2:0]  m_cause;
   logic [31:0] m_hpc;
   logic [63:0] m_cyc;
   logic [31:0] m_stk;
   logic [31:0] m_spc;
   bit          m_prev_pulse;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_halted = 0; m_pulse = 0; m_cause = 3'd0; m_hpc = 32'h0;
      m_cyc = 64'h0; m_stk = 32'h0; m_spc = 32'hFFFF_FFFF;
   endtask

   task automatic model_step();
      logic [2:0]  c;
      logic [31:0] cpc;
      m_prev_pulse = m_pulse;
      if (rst) begin
         model_reset();
      end else if (m_halted) begin
         m_pulse = 0;
         if (clear) model_reset();
      end else begin
         c = 3'd0; cpc = 32'h0;
         if (ecall_pulse)       begin c = 3'd1; cpc = pc;     end
         else if (ebreak_pulse) begin c = 3'd2; cpc = pc;     end
         else if (m_stk == SL)  begin c = 3'd3; cpc = m_spc;  end
         else if (m_cyc == TO)  begin c = 3'd4; cpc = mem_pc; end
         if (mem_pc == m_spc) begin
            if (m_stk != 32'hFFFF_FFFF) m_stk = m_stk + 1;
         end else begin
            m_spc = mem_pc;
            m_stk = 0;
         end
         if (c != 0) begin
            m_halted = 1; m_pulse = 1; m_cause = c; m_hpc = cpc;
         end else begin
            m_pulse = 0;
            m_cyc = m_cyc + 1;
         end
      end
   endtask

   task automatic check_all();
      chk("halted", {63'h0, halted}, {63'h0, m_halted});
      chk("halt_pulse", {63'h0, halt_pulse}, {63'h0, m_pulse});
      chk("halt_cause", {61'h0, halt_cause}, {61'h0, m_cause});
      chk("halt_pc", {32'h0, halt_pc}, {32'h0, m_hpc});
      chk("cycle_count", cycle_count, m_cyc);
      chk("stuck_count", {32'h0, stuck_count}, {32'h0, m_stk});
      if (m_prev_pulse && halt_pulse) begin
         errors++;
         $display("FAIL pulse_twice: halt_pulse high on consecutive cycles at %0t", $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic do_reset();
      rst = 1; ecall_pulse = 0; ebreak_pulse = 0; clear = 0;
      tick();
      rst = 0;
   endtask

   initial begin
      model_reset();
      m_prev_pulse = 0;

      // ECALL on edge 10 with incrementing mem_pc
      do_reset();
      chk("rst_halted", {63'h0, halted}, 64'd0);
      chk("rst_stuck_count", {32'h0, stuck_count}, 64'd0);
      for (int e = 1; e <= 10; e++) begin
         mem_pc = 32'(4 * e);
         pc = (e == 10) ? 32'h120 : $urandom;
         ecall_pulse = (e == 10);
         tick();
      end
      ecall_pulse = 0;
      chk("ecall_halted", {63'h0, halted}, 64'd1);
      chk("ecall_pulse_out", {63'h0, halt_pulse}, 64'd1);
      chk("ecall_cause", {61'h0, halt_cause}, 64'd1);
      chk("ecall_pc", {32'h0, halt_pc}, 64'h120);
      chk("ecall_cycles", cycle_count, 64'd9);
      tick();
      chk("pulse_one_cycle", {63'h0, halt_pulse}, 64'd0);
      clear = 1;
      tick();
      clear = 0;
      chk("clear_halted", {63'h0, halted}, 64'd0);
      chk("clear_cycles", cycle_count, 64'd0);
      chk("clear_cause", {61'h0, halt_cause}, 64'd0);
      chk("clear_pc", {32'h0, halt_pc}, 64'd0);

      // Stuck mem_pc
      do_reset();
      mem_pc = 32'h40;
      for (int e = 1; e <= 5; e++) tick();
      chk("stuck_cnt4", {32'h0, stuck_count}, 64'd4);
      chk("stuck_not_yet", {63'h0, halted}, 64'd0);
      tick();
      chk("stuck_halted", {63'h0, halted}, 64'd1);
      chk("stuck_cause", {61'h0, halt_cause}, 64'd3);
      chk("stuck_pc", {32'h0, halt_pc}, 64'h40);

      // ECALL + EBREAK together while stuck_count == limit
      do_reset();
      mem_pc = 32'h40;
      for (int e = 1; e <= 5; e++) tick();
      ecall_pulse = 1; ebreak_pulse = 1; pc = 32'h200;
      tick();
      ecall_pulse = 0; ebreak_pulse = 0;
      chk("prio_cause", {61'h0, halt_cause}, 64'd1);
      chk("prio_pc", {32'h0, halt_pc}, 64'h200);
      tick();
      ebreak_pulse = 1;
      tick();
      ebreak_pulse = 0;
      chk("halt_ebreak_pulse", {63'h0, halt_pulse}, 64'd0);
      chk("halt_ebreak_cause", {61'h0, halt_cause}, 64'd1);

      // Timeout
      do_reset();
      for (int e = 1; e <= 21; e++) begin
         mem_pc = 32'h1000 + 32'(4 * e);
         tick();
         if (e == 20) begin
            chk("to_not_yet", {63'h0, halted}, 64'd0);
            chk("to_cycles20", cycle_count, 64'd20);
         end
      end
      chk("to_halted", {63'h0, halted}, 64'd1);
      chk("to_cause", {61'h0, halt_cause}, 64'd4);
      chk("to_cycles", cycle_count, 64'd20);
      chk("to_pc", {32'h0, halt_pc}, 64'h1054);

      // Reset mid stuck run
      do_reset();
      mem_pc = 32'h80;
      tick();
      tick();
      rst = 1;
      tick();
      rst = 0;
      chk("midrst_cycles", cycle_count, 64'd0);
      chk("midrst_stuck", {32'h0, stuck_count}, 64'd0);
      for (int e = 1; e <= 5; e++) tick();
      chk("midrst_no_halt", {63'h0, halted}, 64'd0);
      tick();
      chk("midrst_halt", {63'h0, halted}, 64'd1);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         ecall_pulse = ($urandom_range(0, 39) == 0);
         ebreak_pulse = ($urandom_range(0, 39) == 0);
         clear = ($urandom_range(0, 7) == 0);
         pc = $urandom;
         if ($urandom_range(0, 3) == 0) mem_pc = 32'(4 * $urandom_range(0, 3));
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
